// File: rtl/axi_write_burst.sv
// Packs an AXI-Stream of beats into fixed-length INCR write bursts on an AXI4 master port,
// walking 4 KB slots 0x0000..0xF000 and pulsing o_wr_done once each burst's response returns.
module axi_write_burst #(
   parameter int AW_FLIP_BYTE  = 0,
   parameter int AW_ADDR_WIDTH = 32,
   parameter int AW_DATA_WIDTH = 64,
   parameter int AW_LIN        = 16
) (
   input  logic                       S_WR_aclk,
   input  logic                       S_WR_aresetn,
   input  logic [AW_DATA_WIDTH-1:0]   S_WR_tdata,
   input  logic                       S_WR_tvalid,
   input  logic                       S_WR_tlast,
   output logic                       S_WR_tready,
   output logic                       o_wr_done,
   output logic                       o_wr_err,
   output logic                       o_frame_err,
   output logic                       m_axi_awid,
   output logic [AW_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                 m_axi_awlen,
   output logic [2:0]                 m_axi_awsize,
   output logic [1:0]                 m_axi_awburst,
   output logic                       m_axi_awlock,
   output logic [3:0]                 m_axi_awcache,
   output logic [2:0]                 m_axi_awprot,
   output logic [3:0]                 m_axi_awqos,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,
   output logic [AW_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AW_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                       m_axi_wlast,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,
   input  logic                       m_axi_bid,
   input  logic [1:0]                 m_axi_bresp,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready
);

   localparam int STRB_W = AW_DATA_WIDTH / 8;

   // Number of bits needed to hold value; clogb2(bytes-1) gives the AXI size code.
   function automatic int clogb2(input int value);
      int bits;
      bits = 0;
      for (int v = value; v > 0; v = v >> 1) begin
         bits++;
      end
      return bits;
   endfunction

   localparam logic [8:0]               LAST_BEAT = 9'(AW_LIN - 1);
   localparam logic [AW_ADDR_WIDTH-1:0] SLOT_STEP = AW_ADDR_WIDTH'(32'h0000_1000);
   localparam logic [AW_ADDR_WIDTH-1:0] SLOT_LAST = AW_ADDR_WIDTH'(32'h0000_F000);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      WR_RESP = 3'd3,
      WR_DONE = 3'd4
   } state_t;

   state_t                   state_reg, state_next;
   logic [8:0]               beat_cnt_reg, beat_cnt_next;
   logic [AW_ADDR_WIDTH-1:0] wr_addr_buff_reg, wr_addr_buff_next;
   logic                     wr_err_reg, wr_err_next;

   logic [AW_DATA_WIDTH-1:0] tdata_flipped;
   logic [AW_DATA_WIDTH-1:0] beat_data;
   logic                     is_last_beat;
   logic                     w_xfer;

   // Response ID carries no information for a single-ID master.
   logic unused_bid;
   assign unused_bid = m_axi_bid;

   genvar gi;
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_flip
         assign tdata_flipped[gi*8 +: 8] = S_WR_tdata[(STRB_W-1-gi)*8 +: 8];
      end
   endgenerate

   assign beat_data    = (AW_FLIP_BYTE != 0) ? tdata_flipped : S_WR_tdata;
   assign is_last_beat = (beat_cnt_reg == LAST_BEAT);
   assign w_xfer       = S_WR_tvalid && m_axi_wready;

   assign m_axi_awid    = 1'b0;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'd3;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign m_axi_awlen   = 8'(AW_LIN - 1);
   assign m_axi_awsize  = 3'(clogb2(STRB_W - 1));
   assign m_axi_awburst = 2'd1;
   assign m_axi_wstrb   = '1;
   assign m_axi_awaddr  = wr_addr_buff_reg;
   assign o_wr_err      = wr_err_reg;

   always_ff @(posedge S_WR_aclk or negedge S_WR_aresetn) begin
      if (!S_WR_aresetn) begin
         state_reg        <= IDLE;
         beat_cnt_reg     <= '0;
         wr_addr_buff_reg <= '0;
         wr_err_reg       <= 1'b0;
      end else begin
         state_reg        <= state_next;
         beat_cnt_reg     <= beat_cnt_next;
         wr_addr_buff_reg <= wr_addr_buff_next;
         wr_err_reg       <= wr_err_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      beat_cnt_next     = beat_cnt_reg;
      wr_addr_buff_next = wr_addr_buff_reg;
      wr_err_next       = wr_err_reg;
      S_WR_tready       = 1'b0;
      m_axi_awvalid     = 1'b0;
      m_axi_wvalid      = 1'b0;
      m_axi_wlast       = 1'b0;
      m_axi_wdata       = '0;
      m_axi_bready      = 1'b0;
      o_wr_done         = 1'b0;
      o_frame_err       = 1'b0;

      case (state_reg)
         IDLE: begin
            // The first beat stays on the stream until the address is accepted.
            if (S_WR_tvalid) begin
               state_next = WR_ADDR;
            end
         end

         WR_ADDR: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) begin
               state_next = WR_DATA;
            end
         end

         WR_DATA: begin
            m_axi_wvalid = S_WR_tvalid;
            S_WR_tready  = m_axi_wready;
            m_axi_wdata  = beat_data;
            m_axi_wlast  = is_last_beat;
            if (w_xfer) begin
               // Burst length is fixed; tlast is only checked, never obeyed.
               o_frame_err = (S_WR_tlast != is_last_beat);
               if (is_last_beat) begin
                  beat_cnt_next = '0;
                  state_next    = WR_RESP;
               end else begin
                  beat_cnt_next = beat_cnt_reg + 9'd1;
               end
            end
         end

         WR_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               if (m_axi_bresp != 2'b00) begin
                  wr_err_next = 1'b1;
               end
               state_next = WR_DONE;
            end
         end

         WR_DONE: begin
            o_wr_done = 1'b1;
            if (wr_addr_buff_reg >= SLOT_LAST) begin
               wr_addr_buff_next = '0;
            end else begin
               wr_addr_buff_next = wr_addr_buff_reg + SLOT_STEP;
            end
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_write_burst.sv
// Randomized bench for axi_write_burst: a stream source and AXI slave drive the DUT while a
// burst-level reference model predicts channel activity, addresses, data and error flags.
module tb_axi_write_burst;

   localparam int DW  = 64;
   localparam int AW  = 32;
   localparam int LIN = 16;
   localparam int SW  = DW / 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic          wr_done, wr_err, frame_err;
   logic          awid, awlock;
   logic [3:0]    awcache, awqos;
   logic [2:0]    awprot, awsize;
   logic [AW-1:0] awaddr;
   logic [7:0]    awlen;
   logic [1:0]    awburst;
   logic          awvalid;
   logic          awready = 1'b0;
   logic [DW-1:0] wdata;
   logic [SW-1:0] wstrb;
   logic          wlast, wvalid;
   logic          wready = 1'b0;
   logic          bid = 1'b0;
   logic [1:0]    bresp = 2'b00;
   logic          bvalid = 1'b0;
   logic          bready;

   axi_write_burst #(
      .AW_FLIP_BYTE(0), .AW_ADDR_WIDTH(AW), .AW_DATA_WIDTH(DW), .AW_LIN(LIN)
   ) dut (
      .S_WR_aclk(clk), .S_WR_aresetn(rst_n),
      .S_WR_tdata(s_tdata), .S_WR_tvalid(s_tvalid), .S_WR_tlast(s_tlast), .S_WR_tready(s_tready),
      .o_wr_done(wr_done), .o_wr_err(wr_err), .o_frame_err(frame_err),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
      .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
      .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
      .m_axi_wready(wready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready)
   );

   // Byte-flip instance: 32-bit data, short bursts, always-ready slave.
   logic [31:0] f_tdata = '0;
   logic        f_tvalid = 1'b0;
   logic        f_tlast = 1'b0;
   logic        f_tready, f_done, f_err, f_frame;
   logic        f_awid, f_awlock, f_awvalid, f_wlast, f_wvalid, f_bready;
   logic [3:0]  f_awcache, f_awqos, f_wstrb;
   logic [2:0]  f_awprot, f_awsize;
   logic [31:0] f_awaddr, f_wdata;
   logic [7:0]  f_awlen;
   logic [1:0]  f_awburst;
   logic        f_awready = 1'b1;
   logic        f_wready = 1'b1;
   logic        f_bid = 1'b0;
   logic [1:0]  f_bresp = 2'b00;
   logic        f_bvalid = 1'b1;

   axi_write_burst #(
      .AW_FLIP_BYTE(1), .AW_ADDR_WIDTH(32), .AW_DATA_WIDTH(32), .AW_LIN(4)
   ) dut_flip (
      .S_WR_aclk(clk), .S_WR_aresetn(rst_n),
      .S_WR_tdata(f_tdata), .S_WR_tvalid(f_tvalid), .S_WR_tlast(f_tlast), .S_WR_tready(f_tready),
      .o_wr_done(f_done), .o_wr_err(f_err), .o_frame_err(f_frame),
      .m_axi_awid(f_awid), .m_axi_awaddr(f_awaddr), .m_axi_awlen(f_awlen), .m_axi_awsize(f_awsize),
      .m_axi_awburst(f_awburst), .m_axi_awlock(f_awlock), .m_axi_awcache(f_awcache),
      .m_axi_awprot(f_awprot), .m_axi_awqos(f_awqos), .m_axi_awvalid(f_awvalid),
      .m_axi_awready(f_awready), .m_axi_wdata(f_wdata), .m_axi_wstrb(f_wstrb),
      .m_axi_wlast(f_wlast), .m_axi_wvalid(f_wvalid), .m_axi_wready(f_wready),
      .m_axi_bid(f_bid), .m_axi_bresp(f_bresp), .m_axi_bvalid(f_bvalid), .m_axi_bready(f_bready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 50)
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] byte_rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = v[8*(3-i) +: 8];
      return r;
   endfunction

   // Reference model: which channel is open, beat position, burst count, sticky error.
   typedef enum int {P_IDLE, P_ADDR, P_DATA, P_RESP, P_DONE} phase_e;
   typedef struct { logic [DW-1:0] d; bit last; } beat_t;

   phase_e      ph = P_IDLE;
   int          beat = 0;
   int          burst_idx = 0;
   bit          exp_err = 1'b0;
   beat_t       src_q[$];
   logic [31:0] aw_log[$];
   bit          src_on = 1'b0;
   int          gap_cnt = 0;
   int          cyc = 0, tv_cyc = 0, done_cyc = 0;
   int          obs_done = 0, obs_frame = 0;

   // Stimulus knobs and slave state.
   int          aw_delay = 0, wready_mode = 0, gap_cfg = 0, b_delay = 0;
   int          aw_wait = 0, b_wait = 0;
   bit          b_pend = 1'b0, wtog = 1'b0;
   logic [1:0]  bresp_next = 2'b00;

   task automatic monitor();
      bit exp_frame;
      cyc++;
      check("awvalid", 64'(awvalid), 64'(ph == P_ADDR));
      check("wvalid", 64'(wvalid), 64'(ph == P_DATA && s_tvalid));
      check("tready", 64'(s_tready), 64'(ph == P_DATA && wready));
      check("bready", 64'(bready), 64'(ph == P_RESP));
      check("wr_done", 64'(wr_done), 64'(ph == P_DONE));
      check("wr_err", 64'(wr_err), 64'(exp_err));
      if (ph == P_DATA) check("wlast", 64'(wlast), 64'(beat == LIN - 1));
      exp_frame = (ph == P_DATA) && s_tvalid && wready && (s_tlast != (beat == LIN - 1));
      check("frame_err", 64'(frame_err), 64'(exp_frame));
      if (wr_done) begin obs_done++; done_cyc = cyc; end
      if (frame_err) obs_frame++;
      case (ph)
         P_IDLE: if (s_tvalid) begin ph = P_ADDR; tv_cyc = cyc; end
         P_ADDR: if (awready) begin
            check("awaddr", 64'(awaddr), 64'((burst_idx % 16) * 4096));
            check("awlen", 64'(awlen), 64'(LIN - 1));
            check("awsize", 64'(awsize), 64'd3);
            check("awburst", 64'(awburst), 64'd1);
            aw_log.push_back(awaddr);
            ph = P_DATA;
         end
         P_DATA: if (s_tvalid && wready) begin
            check("wdata", 64'(wdata), 64'(src_q[0].d));
            if (beat == LIN - 1) begin beat = 0; ph = P_RESP; end
            else beat++;
         end
         P_RESP: if (bvalid) begin
            if (bresp != 2'b00) exp_err = 1'b1;
            ph = P_DONE;
         end
         default: begin burst_idx++; ph = P_IDLE; end
      endcase
      if (awvalid && awready) aw_wait = 0;
      else if (awvalid) aw_wait++;
      if (wvalid && wready && wlast) begin b_pend = 1'b1; b_wait = 0; end
      else if (bvalid && bready) b_pend = 1'b0;
      else if (b_pend) b_wait++;
      if (s_tvalid && s_tready) begin
         void'(src_q.pop_front());
         src_on = 1'b0;
         gap_cnt = (gap_cfg < 0) ? $urandom_range(0, 3) : gap_cfg;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      if (!src_on) begin
         if (gap_cnt > 0) gap_cnt--;
         else if (src_q.size() > 0) src_on = 1'b1;
      end
      s_tvalid = src_on;
      s_tdata  = src_on ? src_q[0].d : '0;
      s_tlast  = src_on && src_q[0].last;
      awready  = awvalid ? (aw_wait >= aw_delay) : 1'($urandom_range(0, 1));
      case (wready_mode)
         0: wready = 1'b1;
         1: begin wtog = ~wtog; wready = wtog; end
         default: wready = 1'($urandom_range(0, 1));
      endcase
      bvalid = b_pend && (b_wait >= b_delay);
      bresp  = bvalid ? bresp_next : 2'b00;
      bid    = 1'($urandom_range(0, 1));
      @(negedge clk);
      monitor();
   endtask

   // frame_pos: -1 tlast only on the final beat, -2 no tlast at all, else an extra early tlast.
   task automatic run_burst(input int frame_pos, input logic [1:0] resp);
      beat_t b;
      int    start;
      bresp_next = resp;
      for (int i = 0; i < LIN; i++) begin
         b.d = {$urandom, $urandom};
         if (frame_pos == -2) b.last = 1'b0;
         else b.last = (i == LIN - 1) || (i == frame_pos);
         src_q.push_back(b);
      end
      start = obs_done;
      for (int i = 0; i < LIN * 12 + 40 && obs_done == start; i++) cycle();
      check("burst_complete", 64'(obs_done), 64'(start + 1));
   endtask

   task automatic model_reset();
      ph = P_IDLE; beat = 0; burst_idx = 0; exp_err = 1'b0;
      src_q.delete(); aw_log.delete();
      src_on = 1'b0; gap_cnt = 0; b_pend = 1'b0; b_wait = 0; aw_wait = 0;
      s_tvalid = 1'b0; s_tlast = 1'b0; bvalid = 1'b0; awready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int fr0;
      bit seen;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_awvalid", 64'(awvalid), 64'd0);
      check("rst_wvalid", 64'(wvalid), 64'd0);
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_bready", 64'(bready), 64'd0);
      check("rst_done", 64'(wr_done), 64'd0);
      check("rst_err", 64'({wr_err, frame_err}), 64'd0);
      check("rst_awaddr", 64'(awaddr), 64'd0);
      check("rst_wlast_wdata", 64'(wlast) | 64'(wdata), 64'd0);
      check("rst_awcache", 64'(awcache), 64'd3);
      check("rst_awlen", 64'(awlen), 64'd15);
      check("rst_awsize", 64'(awsize), 64'd3);
      check("rst_awburst", 64'(awburst), 64'd1);
      check("rst_wstrb", 64'(wstrb), 64'hff);
      check("rst_zero_fields", 64'({awid, awlock, awprot, awqos}), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;

      // Burst 0: everything ready, continuous stream.
      aw_delay = 0; wready_mode = 0; gap_cfg = 0; b_delay = 0;
      run_burst(-1, 2'b00);
      check("basic_latency", 64'(done_cyc - tv_cyc), 64'(LIN + 3));
      $display("burst 0 basic: awaddr=0x%0h done_latency=%0d", aw_log[0], done_cyc - tv_cyc);

      // Burst 1: AW delayed 5 cycles, wready toggling, 3-cycle stream gaps.
      aw_delay = 5; wready_mode = 1; gap_cfg = 3; b_delay = 2;
      run_burst(-1, 2'b00);
      $display("burst 1 backpressure: awaddr=0x%0h", aw_log[1]);

      // Burst 2: SLVERR response; burst 3: early tlast on beat 7.
      aw_delay = 1; wready_mode = 0; gap_cfg = 0; b_delay = 0;
      run_burst(-1, 2'b10);
      check("err_set", 64'(wr_err), 64'd1);
      $display("burst 2 slverr: wr_err=%0b", wr_err);
      fr0 = obs_frame;
      run_burst(7, 2'b00);
      check("err_sticky", 64'(wr_err), 64'd1);
      check("frame_pulses", 64'(obs_frame - fr0), 64'd1);
      $display("burst 3 frame: frame_pulses=%0d wr_err=%0b", obs_frame - fr0, wr_err);

      // Bursts 4..16: random backpressure and framing; 17 bursts wraps the address.
      for (int k = 4; k < 17; k++) begin
         int fp;
         aw_delay = $urandom_range(0, 3); wready_mode = 2; gap_cfg = -1;
         b_delay = $urandom_range(0, 3);
         fp = -1;
         if ($urandom_range(0, 3) == 0) fp = int'($urandom_range(0, LIN - 1));
         else if ($urandom_range(0, 5) == 0) fp = -2;
         run_burst(fp, 2'($urandom_range(0, 3)));
         $display("burst %0d random: awaddr=0x%0h", k, aw_log[k]);
      end
      check("wrap_f000", 64'(aw_log[15]), 64'h0000_F000);
      check("wrap_zero", 64'(aw_log[16]), 64'd0);

      // Reset during beat 9 of a burst.
      aw_delay = 0; wready_mode = 0; gap_cfg = 0; b_delay = 0; bresp_next = 2'b00;
      for (int i = 0; i < LIN; i++) src_q.push_back('{d: {$urandom, $urandom}, last: (i == LIN - 1)});
      for (int i = 0; i < 100 && !(ph == P_DATA && beat == 9); i++) cycle();
      check("reached_beat9", 64'(beat), 64'd9);
      @(posedge clk); #1; rst_n = 1'b0; #1;
      check("arst_valids", 64'({awvalid, wvalid, s_tready, bready, wr_done}), 64'd0);
      check("arst_awaddr_err", 64'(awaddr) | 64'(wr_err), 64'd0);
      model_reset();
      repeat (3) cycle();
      @(posedge clk); #1; rst_n = 1'b1;
      run_burst(-1, 2'b00);
      check("post_rst_awaddr", 64'(aw_log[0]), 64'd0);
      $display("reset mid-burst: next awaddr=0x%0h wr_err=%0b", aw_log[0], wr_err);

      // Byte flip on the 32-bit instance.
      @(posedge clk); #1;
      f_tdata = 32'h1122_3344; f_tvalid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         seen = 1'b0;
         for (int t = 0; t < 12 && !seen; t++) begin
            @(negedge clk);
            if (f_wvalid && f_wready) seen = 1'b1;
         end
         check("flip_beat_seen", 64'(seen), 64'd1);
         if (k == 0) check("flip_fixed", 64'(f_wdata), 64'h4433_2211);
         else check("flip_rand", 64'(f_wdata), 64'(byte_rev32(f_tdata)));
         $display("flip beat %0d: tdata=0x%08h wdata=0x%08h", k, f_tdata, f_wdata);
         @(posedge clk); #1;
         f_tdata = $urandom;
      end
      f_tvalid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
